lsu_mem_ctrl: RTL and testbench
===============================

// Module: lsu_mem_ctrl
// PURPOSE
//  Load/store unit between the datapath's memory port and a word-wide data bus with req/ack handshake.
//  - Takes the ALU result as the byte address, the store data, and func3.
//  - Drives aligned bus transactions: byte-enables, lane shifting, load extraction and sign/zero extension.
//  - Holds the core with stall while a transfer is outstanding.
//  - Returns the load result that the core writes back to its register file.
// PARAMETERS
//  BUS_TIMEOUT  15  cycles in REQ without bus_ack before the access is aborted (1..255)
// PORTS
//  clk        in   1   system clock, rising edge
//  rst        in   1   asynchronous reset, active-high
//  mem_rd     in   1   load request from control, level, held while stall=1
//  mem_wr     in   1   store request from control, level, held while stall=1
//  func3      in   3   RV32I load/store width code
//  addr       in   32  byte address (ALU result)
//  wr_data    in   32  store source (rs2 value)
//  rd_data    out  32  extended load result, registered
//  stall      out  1   core must hold PC/instruction this cycle
//  misalign   out  1   1-cycle pulse: misaligned or unsupported access, no bus cycle issued
//  bus_err    out  1   1-cycle pulse: bus timeout
//  bus_req    out  1   bus request
//  bus_we     out  1   1=write, 0=read
//  bus_addr   out  32  word address {addr[31:2],2'b00}
//  bus_wdata  out  32  lane-replicated store data
//  bus_be     out  4   byte enables (all 1 on reads)
//  bus_ack    in   1   1-cycle transfer complete
//  bus_rdata  in   32  read data, valid with bus_ack
// BEHAVIOUR
//  Reset: state=IDLE, timeout counter=0, all outputs 0.
//  - Reset mid-transfer drops bus_req immediately and abandons the transfer.
//  FSM: IDLE -> REQ -> DONE -> IDLE.
//  IDLE, access requested (mem_rd|mem_wr), func3/addr legal:
//  - Latch addr, func3, bus_we, bus_be and bus_wdata; go to REQ.
//  - stall=1 combinationally in this same cycle.
//  - mem_rd and mem_wr both high: treated as a store.
//  REQ:
//  - bus_req=1, stall=1. Bus outputs are held stable until bus_ack.
//  - Counter increments each cycle.
//  - On bus_ack: for a load, register the extended result into rd_data. Go to DONE.
//  - If the counter reaches BUS_TIMEOUT with no ack: drop bus_req, rd_data=0, pulse bus_err, go to DONE.
//  - A bus_ack in the same cycle as the timeout wins (normal completion).
//  DONE:
//  - stall=0, bus_req=0. The core retires the instruction at this edge.
//  - Always returns to IDLE. A request still visible in DONE is not restarted.
//  Legal accesses: load 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store 000 SB, 001 SH, 010 SW.
//  Misaligned or unsupported access:
//  - Misaligned: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
//  - Any other func3 is unsupported.
//  - Response: stay in IDLE, misalign=1 for that cycle, stall=0, no bus cycle, rd_data=0.
//  Store formatting:
//  - SB: bus_wdata={4{wr_data[7:0]}}, bus_be=4'b0001<<addr[1:0].
//  - SH: bus_wdata={2{wr_data[15:0]}}, bus_be=4'b0011<<{addr[1],1'b0}.
//  - SW: bus_wdata=wr_data, bus_be=4'b1111.
//  Load extraction: byte lane addr[1:0] (half lane addr[1]); sign-extend LB/LH, zero-extend LBU/LHU.
//  rd_data holds its value until the next load completes or fails; stores do not change it.
//  Latency: one bus wait cycle gives stall high for 2 cycles (IDLE, REQ); the result is usable in DONE.
// TESTING
//  1. LW addr=0x100, ack 1 cycle after req, rdata=0xDEADBEEF -> bus_addr=0x100, be=1111; stall high 2 cycles; rd_data=0xDEADBEEF in DONE.
//  2. LB addr=0x103, rdata=0x80FF_0000 -> rd_data=0xFFFFFF80; same access as LBU -> 0x00000080.
//  3. SH addr=0x22, wr_data=0x1234ABCD -> bus_we=1, be=1100, bus_wdata=0xABCDABCD, bus_addr=0x20.
//  4. LW addr=0x102 -> misalign pulse 1 cycle, bus_req never asserted, stall=0, rd_data=0.
//  5. No ack with BUS_TIMEOUT=15 -> bus_req high 15 cycles, bus_err pulse, rd_data=0, stall released next cycle.
//  6. rst asserted while in REQ -> bus_req=0 asynchronously, stall=0; after release a fresh LW completes normally.

Source files
------------

// File: rtl/lsu_mem_ctrl_if.sv
// rtl/lsu_mem_ctrl_if.sv - word-wide data bus between the LSU and memory
interface lsu_mem_ctrl_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_wdata,
        output bus_be,
        input  bus_ack,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_wdata,
        input  bus_be,
        output bus_ack,
        output bus_rdata
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - load/store unit driving an aligned word bus with req/ack handshake
module lsu_mem_ctrl #(
    parameter int BUS_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_rd,
    input  logic                  mem_wr,
    input  logic [2:0]            func3,
    input  logic [31:0]           addr,
    input  logic [31:0]           wr_data,
    output logic [31:0]           rd_data,
    output logic                  stall,
    output logic                  misalign,
    output logic                  bus_err,
    lsu_mem_ctrl_if.master        bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [7:0] TO_LAST = 8'(BUS_TIMEOUT - 1);

    logic [1:0]  state;
    logic [7:0]  cnt;
    logic [2:0]  f3_q;
    logic [1:0]  lane_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;

    logic        access;
    logic        legal;
    logic        start;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;

    assign access = mem_rd | mem_wr;

    // A simultaneous read and write request is decoded with store rules.
    always_comb begin
        legal = 1'b0;
        if (mem_wr) begin
            case (func3)
                3'b000:  legal = 1'b1;
                3'b001:  legal = ~addr[0];
                3'b010:  legal = (addr[1:0] == 2'b00);
                default: legal = 1'b0;
            endcase
        end else begin
            case (func3)
                3'b000, 3'b100: legal = 1'b1;
                3'b001, 3'b101: legal = ~addr[0];
                3'b010:         legal = (addr[1:0] == 2'b00);
                default:        legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        be_next    = 4'b1111;
        wdata_next = '0;
        if (mem_wr) begin
            case (func3)
                3'b000: begin
                    be_next    = 4'b0001 << addr[1:0];
                    wdata_next = {4{wr_data[7:0]}};
                end
                3'b001: begin
                    be_next    = 4'b0011 << {addr[1], 1'b0};
                    wdata_next = {2{wr_data[15:0]}};
                end
                default: begin
                    be_next    = 4'b1111;
                    wdata_next = wr_data;
                end
            endcase
        end
    end

    assign start    = ~rst & (state == S_IDLE) & access & legal;
    assign misalign = ~rst & (state == S_IDLE) & access & ~legal;
    assign stall    = ~rst & ((state == S_REQ) | start);

    assign bus.bus_req   = (state == S_REQ);
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
    assign bus.bus_be    = be_q;

    function automatic logic [31:0] load_ext(input logic [2:0]  f3,
                                             input logic [1:0]  lane,
                                             input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{lane, 3'b000} +: 8];
        h = lane[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b100:  load_ext = {24'h0, b};
            3'b101:  load_ext = {16'h0, h};
            default: load_ext = d;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            f3_q    <= '0;
            lane_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rd_data <= '0;
            bus_err <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        addr_q  <= {addr[31:2], 2'b00};
                        lane_q  <= addr[1:0];
                        f3_q    <= func3;
                        we_q    <= mem_wr;
                        be_q    <= be_next;
                        wdata_q <= wdata_next;
                        state   <= S_REQ;
                    end else if (misalign && !mem_wr) begin
                        rd_data <= '0;
                    end
                end
                S_REQ: begin
                    // An ack arriving in the final timeout cycle still completes normally.
                    if (bus.bus_ack) begin
                        if (!we_q)
                            rd_data <= load_ext(f3_q, lane_q, bus.bus_rdata);
                        cnt   <= '0;
                        state <= S_DONE;
                    end else if (cnt == TO_LAST) begin
                        if (!we_q)
                            rd_data <= '0;
                        bus_err <= 1'b1;
                        cnt     <= '0;
                        state   <= S_DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - scoreboard bench for lsu_mem_ctrl with randomized accesses
module tb_lsu_mem_ctrl;
    localparam int BUS_TIMEOUT = 15;
    localparam int NO_ACK = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_rd = 1'b0;
    logic        mem_wr = 1'b0;
    logic [2:0]  func3 = '0;
    logic [31:0] addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic        stall;
    logic        misalign;
    logic        bus_err;

    lsu_mem_ctrl_if bus ();

    lsu_mem_ctrl #(.BUS_TIMEOUT(BUS_TIMEOUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .func3    (func3),
        .addr     (addr),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .stall    (stall),
        .misalign (misalign),
        .bus_err  (bus_err),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          illegal;
        bit          timeout;
        int          lat;
        logic [31:0] baddr;
        bit          we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rd;
    } exp_t;

    typedef struct {
        int          lat;
        logic [31:0] rdata;
    } rsp_t;

    exp_t exp_q[$];
    rsp_t rsp_q[$];

    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    logic [31:0] model_rd = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, expv);
        end
    endtask

    function automatic bit legal_f(input bit wr, input logic [2:0] f3, input logic [31:0] a);
        int size;
        size = int'(f3[1:0]);
        if (size == 3) return 1'b0;
        if (wr && f3[2]) return 1'b0;
        if (f3[2] && size == 2) return 1'b0;
        return (int'(a[1:0]) % (1 << size)) == 0;
    endfunction

    function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rdata);
        int          size;
        int          bits;
        logic [31:0] sh;
        logic [31:0] mask;
        logic [31:0] v;
        size = int'(f3[1:0]);
        bits = 8 << size;
        sh   = rdata >> (8 * int'(a[1:0]));
        mask = (size == 2) ? 32'hFFFF_FFFF : ((32'h1 << bits) - 32'h1);
        v    = sh & mask;
        if (!f3[2] && size != 2 && sh[bits-1]) v = v | ~mask;
        return v;
    endfunction

    // Memory side: ack after 'lat' wait cycles of bus_req, never if lat is out of reach.
    initial begin
        int   rcnt;
        rsp_t cur;
        rcnt = 0;
        cur = '{NO_ACK, 32'h0};
        bus.bus_ack = 1'b0;
        bus.bus_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.bus_req) begin
                if (rcnt == 0) cur = (rsp_q.size() > 0) ? rsp_q.pop_front() : '{NO_ACK, 32'h0};
                if (rcnt == cur.lat) begin
                    bus.bus_ack = 1'b1;
                    bus.bus_rdata = cur.rdata;
                end else begin
                    bus.bus_ack = 1'b0;
                    bus.bus_rdata = $urandom;
                end
                rcnt++;
            end else begin
                bus.bus_ack = 1'b0;
                rcnt = 0;
            end
        end
    end

    // Monitor: compares DUT outputs against the queued expectations.
    initial begin
        bit          prev_req;
        int          req_len;
        bit          pend_rd;
        logic [31:0] pend_val;
        exp_t        e;
        prev_req = 1'b0;
        req_len  = 0;
        pend_rd  = 1'b0;
        pend_val = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!mon_en) begin
                prev_req = 1'b0;
                req_len  = 0;
                pend_rd  = 1'b0;
            end else begin
                if (pend_rd) begin
                    chk("misalign_rd_data", rd_data, pend_val);
                    pend_rd = 1'b0;
                end
                if (bus.bus_req) begin
                    req_len++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_bus_req", 32'(bus.bus_req), 32'h0);
                    end else begin
                        e = exp_q[0];
                        chk("bus_addr", bus.bus_addr, e.baddr);
                        chk("bus_we", 32'(bus.bus_we), 32'(e.we));
                        chk("bus_be", 32'(bus.bus_be), 32'(e.be));
                        if (e.we) chk("bus_wdata", bus.bus_wdata, e.wdata);
                        chk("stall_in_req", 32'(stall), 32'h1);
                    end
                end
                if (misalign) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_misalign", 32'(misalign), 32'h0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("misalign_expected", 32'(e.illegal), 32'h1);
                        chk("misalign_stall", 32'(stall), 32'h0);
                        pend_rd  = 1'b1;
                        pend_val = e.rd;
                    end
                end
                if (prev_req && !bus.bus_req) begin
                    if (exp_q.size() == 0) begin
                        chk("done_without_expect", 32'h1, 32'h0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("done_legal", 32'(e.illegal), 32'h0);
                        chk("bus_err", 32'(bus_err), 32'(e.timeout));
                        chk("rd_data", rd_data, e.rd);
                        chk("done_stall", 32'(stall), 32'h0);
                        chk("req_cycles", 32'(req_len), e.timeout ? 32'(BUS_TIMEOUT) : 32'(e.lat + 1));
                    end
                    req_len = 0;
                end else if (bus_err) begin
                    chk("stray_bus_err", 32'(bus_err), 32'h0);
                end
                prev_req = bus.bus_req;
            end
        end
    end

    // Issues one access at a negedge and returns at a negedge once it has retired.
    task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             input int lat, input logic [31:0] rdata);
        exp_t e;
        int   size;
        int   i;
        bit   ok;
        ok   = legal_f(wr, f3, a);
        size = int'(f3[1:0]);
        e.illegal = !ok;
        e.timeout = (lat >= BUS_TIMEOUT);
        e.lat     = lat;
        e.baddr   = a & 32'hFFFF_FFFC;
        e.we      = wr;
        e.be      = 4'hF;
        e.wdata   = '0;
        if (wr && ok) begin
            e.be = 4'(((1 << (1 << size)) - 1) << int'(a[1:0]));
            case (size)
                0:       e.wdata = {4{wd[7:0]}};
                1:       e.wdata = {2{wd[15:0]}};
                default: e.wdata = wd;
            endcase
        end
        if (!wr) begin
            if (!ok || e.timeout) model_rd = '0;
            else model_rd = load_model(f3, a, rdata);
        end
        e.rd = model_rd;
        exp_q.push_back(e);
        if (ok) rsp_q.push_back('{lat, rdata});
        mem_rd = rd; mem_wr = wr; func3 = f3; addr = a; wr_data = wd;
        #1;
        chk("idle_stall", 32'(stall), 32'(ok));
        chk("idle_misalign", 32'(misalign), 32'(!ok));
        if (!ok) begin
            @(negedge clk);
        end else begin
            for (i = 0; i < 100; i++) begin
                @(negedge clk);
                #1;
                if (!stall) break;
            end
            if (i == 100) chk("access_hang", 32'(stall), 32'h0);
            @(negedge clk);
        end
        mem_rd = 1'b0; mem_wr = 1'b0;
    endtask

    initial begin
        bit          rd;
        bit          wr;
        logic [2:0]  f3;
        logic [31:0] a;
        int          lat;
        int          k;
        #3;
        chk("reset_stall", 32'(stall), 32'h0);
        chk("reset_misalign", 32'(misalign), 32'h0);
        chk("reset_bus_err", 32'(bus_err), 32'h0);
        chk("reset_bus_req", 32'(bus.bus_req), 32'h0);
        chk("reset_rd_data", rd_data, 32'h0);
        chk("reset_bus_addr", bus.bus_addr, 32'h0);
        chk("reset_bus_be", 32'(bus.bus_be), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        do_access(1, 0, 3'b010, 32'h100, 32'h0, 0, 32'hDEAD_BEEF);
        do_access(1, 0, 3'b000, 32'h103, 32'h0, 1, 32'h80FF_0000);
        do_access(1, 0, 3'b100, 32'h103, 32'h0, 2, 32'h80FF_0000);
        do_access(0, 1, 3'b001, 32'h22, 32'h1234_ABCD, 0, 32'h0);
        do_access(1, 0, 3'b010, 32'h102, 32'h0, 0, 32'h0);
        do_access(1, 0, 3'b101, 32'h206, 32'h0, BUS_TIMEOUT - 1, 32'hC3A5_1234);
        do_access(1, 0, 3'b010, 32'h300, 32'h0, NO_ACK, 32'h0);
        do_access(1, 1, 3'b000, 32'h41, 32'h0000_00A7, 0, 32'h0);
        do_access(1, 0, 3'b011, 32'h40, 32'h0, 0, 32'h0);

        // Asynchronous reset while a load sits in REQ.
        mon_en = 1'b0;
        rsp_q.push_back('{NO_ACK, 32'h0});
        mem_rd = 1'b1; func3 = 3'b010; addr = 32'h40;
        repeat (3) @(negedge clk);
        chk("rst_pre_req", 32'(bus.bus_req), 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("rst_drops_req", 32'(bus.bus_req), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_rd_data", rd_data, 32'h0);
        mem_rd = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rsp_q.delete();
        exp_q.delete();
        model_rd = '0;
        @(negedge clk);
        mon_en = 1'b1;
        do_access(1, 0, 3'b010, 32'h400, 32'h0, 1, 32'h1357_9BDF);

        for (k = 0; k < 300; k++) begin
            case ($urandom_range(0, 3))
                0:       begin rd = 1; wr = 0; end
                1:       begin rd = 0; wr = 1; end
                2:       begin rd = 1; wr = 1; end
                default: begin rd = 1; wr = 0; end
            endcase
            f3 = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7))
                                              : (wr ? 3'($urandom_range(0, 2))
                                                    : 3'({$urandom_range(0, 1), 2'b00} | $urandom_range(0, 1)));
            if (!wr && $urandom_range(0, 3) == 0) f3 = 3'b010;
            a = $urandom;
            if ($urandom_range(0, 2) != 0) a[1:0] = (f3[1:0] == 2'b10) ? 2'b00 : (f3[1:0] == 2'b01 ? {a[1], 1'b0} : a[1:0]);
            lat = (!wr && $urandom_range(0, 11) == 0) ? NO_ACK : int'($urandom_range(0, 4));
            do_access(rd, wr, f3, a, $urandom, lat, $urandom);
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
